// File: rtl/isqrt_arb_pkg.sv
// Shared constants and the round-robin pick helper for the isqrt arbiter.
package isqrt_arb_pkg;

   localparam int ISQRT_XW = 32;
   localparam int ISQRT_YW = 16;
   localparam int RR_MAXN  = 8;

   // One-hot grant of the first set request at or after ptr, wrapping modulo n.
   function automatic logic [RR_MAXN-1:0] rr_pick(input logic [RR_MAXN-1:0] req,
                                                  input logic [2:0]         ptr,
                                                  input int                 n);
      logic [RR_MAXN-1:0] gnt;
      logic               found;
      logic [2:0]         idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < RR_MAXN; k++) begin
         if (k < n) begin
            idx = 3'((int'(ptr) + k) % n);
            if (!found && req[idx]) begin
               gnt[idx] = 1'b1;
               found    = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/isqrt_arb_tag_fifo.sv
// In-order tag FIFO remembering which requester issued each outstanding isqrt operation.
module isqrt_arb_tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/isqrt_arbiter.sv
// Round-robin arbiter sharing one in-order isqrt unit among N requesters.
// Optional sticky protocol error output enabled by ISQRT_ARBITER_ERR_EN.
module isqrt_arbiter
   import isqrt_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int MAX_OUT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          req_vld,
   input  logic [N*ISQRT_XW-1:0] req_x,
   output logic [N-1:0]          req_rdy,
   output logic [N-1:0]          rsp_vld,
   output logic [ISQRT_YW-1:0]   rsp_y,
   output logic                  isqrt_x_vld,
   output logic [ISQRT_XW-1:0]   isqrt_x,
   input  logic                  isqrt_y_vld,
   input  logic [ISQRT_YW-1:0]   isqrt_y,
   output logic                  busy
`ifdef ISQRT_ARBITER_ERR_EN
   ,
   output logic                  err
`endif
);

   localparam int IDW = $clog2(N);
   localparam int CW  = $clog2(MAX_OUT) + 1;

   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     grant_idx;
   logic [IDW-1:0]     tag_head;
   logic [RR_MAXN-1:0] pick_all;
   logic [CW-1:0]      count;
   logic               full;
   logic               empty;
   logic               pop;

   assign pick_all = rr_pick(RR_MAXN'(req_vld), 3'(rr_ptr), N);

   generate
      if (N < RR_MAXN) begin : g_pick_hi
         logic unused_pick;
         assign unused_pick = |pick_all[RR_MAXN-1:N];
      end
   endgenerate

   // Grants use the registered count, so a same-cycle pop frees its slot only next cycle.
   always_comb begin
      req_rdy   = '0;
      grant_idx = '0;
      isqrt_x   = '0;
      if (rst_n && !full) req_rdy = pick_all[N-1:0];
      for (int i = 0; i < N; i++) begin
         if (req_rdy[i]) begin
            grant_idx = IDW'(i);
            isqrt_x   = req_x[ISQRT_XW*i +: ISQRT_XW];
         end
      end
   end

   assign isqrt_x_vld = |req_rdy;
   assign pop         = isqrt_y_vld && !empty;
   assign busy        = !empty;

   isqrt_arb_tag_fifo #(.W(IDW), .DEPTH(MAX_OUT)) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (isqrt_x_vld),
      .push_data (grant_idx),
      .pop       (pop),
      .pop_data  (tag_head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (isqrt_x_vld) begin
         rr_ptr <= (grant_idx == IDW'(N-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld <= '0;
         rsp_y   <= '0;
      end else begin
         rsp_vld <= pop ? ({{(N-1){1'b0}}, 1'b1} << tag_head) : '0;
         if (pop) rsp_y <= isqrt_y;
      end
   end

`ifdef ISQRT_ARBITER_ERR_EN
   logic [N-1:0] pend_q;

   // A request that was waiting last cycle must still be valid now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         err    <= 1'b0;
      end else begin
         pend_q <= req_vld & ~req_rdy;
         if ((isqrt_y_vld && empty) || (|(pend_q & ~req_vld))) err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Self-checking bench for isqrt_arbiter; also checks err when ISQRT_ARBITER_ERR_EN is defined.
module tb_isqrt_arbiter;

   localparam int N       = 4;
   localparam int MAX_OUT = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_vld;
   logic [N*32-1:0] req_x;
   logic [N-1:0]    req_rdy;
   logic [N-1:0]    rsp_vld;
   logic [15:0]     rsp_y;
   logic            isqrt_x_vld;
   logic [31:0]     isqrt_x;
   logic            isqrt_y_vld;
   logic [15:0]     isqrt_y;
   logic            busy;
`ifdef ISQRT_ARBITER_ERR_EN
   logic            err;
`endif

   always #5 clk = ~clk;

   isqrt_arbiter #(.N(N), .MAX_OUT(MAX_OUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_vld     (req_vld),
      .req_x       (req_x),
      .req_rdy     (req_rdy),
      .rsp_vld     (rsp_vld),
      .rsp_y       (rsp_y),
      .isqrt_x_vld (isqrt_x_vld),
      .isqrt_x     (isqrt_x),
      .isqrt_y_vld (isqrt_y_vld),
      .isqrt_y     (isqrt_y),
      .busy        (busy)
`ifdef ISQRT_ARBITER_ERR_EN
      ,
      .err         (err)
`endif
   );

   typedef struct {
      int          due;
      logic [31:0] x;
   } op_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          lat      = 2;
   int          req_pct  = 0;
   bit          spurious = 0;
   bit          rq_vld [N];
   logic [31:0] rq_x   [N];
   op_t         iq     [$];
   int          tags   [$];
   int          m_ptr     = 0;
   logic [N-1:0] m_rsp_vld = '0;
   logic [15:0]  m_rsp_y   = '0;
   bit           m_err     = 0;

   function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
      longint lo = 0;
      longint hi = 65536;
      longint mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= longint'(x)) lo = mid;
         else hi = mid;
      end
      return 16'(lo);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearModel();
      tags.delete();
      iq.delete();
      m_ptr     = 0;
      m_rsp_vld = '0;
      m_rsp_y   = '0;
      m_err     = 0;
   endtask

   // One clock cycle: drive at the falling edge, check, advance the model, wait a full period.
   task automatic applyStimulus();
      bit          from_iq;
      int          g;
      int          t;
      logic [N-1:0] exp_rdy;
      logic [31:0]  exp_x;

      for (int i = 0; i < N; i++) begin
         req_vld[i]         = rq_vld[i];
         req_x[32*i +: 32]  = rq_x[i];
      end
      from_iq     = (iq.size() > 0) && (iq[0].due <= cyc);
      isqrt_y_vld = 1'b0;
      isqrt_y     = 16'($urandom);
      if (from_iq) begin
         isqrt_y_vld = 1'b1;
         isqrt_y     = isqrt_ref(iq[0].x);
      end else if (spurious) begin
         isqrt_y_vld = 1'b1;
         isqrt_y     = 16'hBEEF;
      end
      #1;

      g = -1;
      if (tags.size() < MAX_OUT) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && rq_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      exp_x   = (g >= 0) ? rq_x[g] : 32'd0;

      checkOutput("req_rdy", 32'(req_rdy), 32'(exp_rdy));
      checkOutput("isqrt_x_vld", 32'(isqrt_x_vld), 32'(g >= 0));
      checkOutput("isqrt_x", isqrt_x, exp_x);
      checkOutput("busy", 32'(busy), 32'(tags.size() != 0));
      checkOutput("rsp_vld", 32'(rsp_vld), 32'(m_rsp_vld));
      checkOutput("rsp_y", 32'(rsp_y), 32'(m_rsp_y));
`ifdef ISQRT_ARBITER_ERR_EN
      checkOutput("err", 32'(err), 32'(m_err));
`endif

      if (isqrt_y_vld && tags.size() != 0) begin
         t         = tags.pop_front();
         m_rsp_vld = N'(1 << t);
         m_rsp_y   = isqrt_y;
      end else begin
         m_rsp_vld = '0;
         if (isqrt_y_vld) m_err = 1;
      end
      if (from_iq) void'(iq.pop_front());
      if (g >= 0) begin
         tags.push_back(g);
         m_ptr = (g + 1) % N;
         iq.push_back('{cyc + lat, rq_x[g]});
         rq_vld[g] = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (!rq_vld[i] && req_pct > 0 && $urandom_range(99) < req_pct) begin
            rq_vld[i] = 1;
            rq_x[i]   = $urandom;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int max_cycles);
      int k = 0;
      while ((tags.size() != 0 || m_rsp_vld != '0) && k < max_cycles) begin
         applyStimulus();
         k++;
      end
      checkOutput("drain_timeout", 32'(tags.size()), 32'd0);
   endtask

   task automatic doReset(input int ncyc);
      #2;
      rst_n       = 1'b0;
      isqrt_y_vld = 1'b0;
      #1;
      checkOutput("rst_req_rdy", 32'(req_rdy), 32'd0);
      checkOutput("rst_isqrt_x_vld", 32'(isqrt_x_vld), 32'd0);
      checkOutput("rst_rsp_vld", 32'(rsp_vld), 32'd0);
      checkOutput("rst_rsp_y", 32'(rsp_y), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef ISQRT_ARBITER_ERR_EN
      checkOutput("rst_err", 32'(err), 32'd0);
`endif
      clearModel();
      repeat (ncyc) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         rq_vld[i] = 1;
         rq_x[i]   = 32'(i + 7);
      end
      req_vld     = '1;
      req_x       = '0;
      isqrt_y_vld = 1'b0;
      isqrt_y     = '0;
      @(negedge clk);
      doReset(2);
      for (int i = 0; i < N; i++) rq_vld[i] = 0;

      $display("[TB] single request from requester 2");
      lat       = 3;
      rq_vld[2] = 1;
      rq_x[2]   = 32'd144;
      applyStimulus();
      drain(20);
      checkOutput("single_rsp_y", 32'(rsp_y), 32'd12);

      $display("[TB] four requesters, fill to MAX_OUT, pop while full");
      doReset(1);
      lat = 8;
      for (int i = 0; i < N; i++) begin
         rq_vld[i] = 1;
         rq_x[i]   = 32'((i + 1) * (i + 1));
      end
      repeat (4) applyStimulus();
      checkOutput("full_count", 32'(tags.size()), 32'd4);
      rq_vld[1] = 1;
      rq_x[1]   = 32'd625;
      drain(60);

      $display("[TB] round-robin wrap from rr_ptr 3");
      lat       = 2;
      rq_vld[2] = 1;
      rq_x[2]   = 32'd50;
      applyStimulus();
      drain(20);
      rq_vld[0] = 1;
      rq_x[0]   = 32'd81;
      rq_vld[3] = 1;
      rq_x[3]   = 32'd100;
      applyStimulus();
      applyStimulus();
      drain(20);

      $display("[TB] reset with three operations outstanding");
      lat = 30;
      for (int i = 0; i < 3; i++) begin
         rq_vld[i] = 1;
         rq_x[i]   = 32'd1000 + 32'(i);
      end
      repeat (3) applyStimulus();
      doReset(2);
      lat       = 4;
      rq_vld[1] = 1;
      rq_x[1]   = 32'd0;
      applyStimulus();
      drain(20);
      checkOutput("post_reset_rsp_y", 32'(rsp_y), 32'd0);

      $display("[TB] spurious isqrt result while idle");
      spurious = 1;
      applyStimulus();
      spurious = 0;
      repeat (3) applyStimulus();

      $display("[TB] randomized traffic");
      req_pct = 35;
      for (int blk = 0; blk < 4; blk++) begin
         lat = $urandom_range(1, 10);
         repeat (150) applyStimulus();
      end
      req_pct = 0;
      drain(100);
      doReset(1);
      applyStimulus();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/isqrt_arbiter.md
Name: isqrt_arbiter

Overview:
- Shares one isqrt instance between N requesters, such as several formula FSMs, each of which needs square roots over time.
- Grants requests round-robin and issues at most one isqrt_x per cycle.
- Records each issued requester ID in an in-order tag FIFO.
- Routes every isqrt_y back to the requester that issued the matching x. This relies on isqrt returning results in issue order.
- Sits between the formula FSMs' isqrt interfaces and the single isqrt instance.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_OUT, 4, maximum outstanding isqrt operations; also the tag FIFO depth (power of 2, at least 2).
- IDW, $clog2(N), requester ID width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  N  per-requester request valid; held until accepted.
- req_x  in  N*32  per-requester operand; requester i uses bits [32*i+31:32*i].
- req_rdy  out  N  one-hot accept; a transfer happens when req_vld[i] and req_rdy[i] are both 1.
- rsp_vld  out  N  one-hot, one-cycle result strobe.
- rsp_y  out  16  result, valid for whichever requester has rsp_vld set.
- isqrt_x_vld  out  1  to isqrt.
- isqrt_x  out  32  to isqrt.
- isqrt_y_vld  in  1  from isqrt.
- isqrt_y  in  16  from isqrt.
- busy  out  1  high while any operation is outstanding (count != 0).

Behaviour:
- Reset (asynchronous, active-low): rr_ptr=0, count=0, FIFO pointers=0, rsp_vld=0, rsp_y=0.
- While rst_n=0, req_rdy=0 and isqrt_x_vld=0.
- Grant logic (combinational):
  - If count==MAX_OUT, no grant is made.
  - Otherwise the first i with req_vld[i]=1, searching from rr_ptr upward with wrap, gets req_rdy[i]=1.
  - count is the registered value. A pop in the same cycle does not free a slot until the next cycle.
- Issue: isqrt_x_vld = |req_rdy; isqrt_x = req_x of the granted requester; isqrt_x = 0 when there is no grant.
- On a grant to i, at the clock edge:
  - push i into the tag FIFO;
  - rr_ptr <= (i+1) mod N.
  - With no grant, rr_ptr holds.
- Return path: when isqrt_y_vld=1 and count!=0, pop the head tag t. On the next cycle rsp_vld[t]=1 and rsp_y=isqrt_y. Return latency is 1 cycle.
- rsp_vld is all zeros in any cycle without a pop. rsp_y holds its last value.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- isqrt_y_vld while count==0 is a spurious result: it is ignored, with no pop and no rsp_vld.
- Pointers wrap modulo MAX_OUT.
- Fairness: with every requester continuously valid, grants rotate 0,1,..,N-1 strictly.
- req_x must be stable only in the accept cycle. Any requester may raise req_vld again on the cycle after its acceptance.
- Reset mid-operation:
  - All outstanding tags are discarded and no rsp_vld is produced for them.
  - isqrt must be reset by the same rst_n so that no stale results arrive.
- Arithmetic: none on data; the datapath is pure muxing. count is $clog2(MAX_OUT)+1 bits.

Optional Feature:
- Macro: ISQRT_ARBITER_ERR_EN.
- When defined:
  - adds output err (1 bit, reset 0, sticky until reset);
  - err is set on a spurious isqrt_y_vld (count==0);
  - err is also set when req_vld[i] drops while req_rdy[i] was 0 in the previous cycle with req_vld[i]=1, i.e. a request withdrawn before acceptance.
- When undefined: no err port and no checking logic; all other behaviour is identical.

Decomposition:
- Package isqrt_arb_pkg:
  - localparam ISQRT_XW=32, ISQRT_YW=16;
  - function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module isqrt_arb_tag_fifo:
  - synchronous FIFO with width IDW and depth MAX_OUT;
  - ports push, push_data, pop, pop_data, count, full, empty;
  - same clk and asynchronous rst_n.
- The top level holds the grant logic, rr_ptr and the response registers.

Test Plan:
- N=4, MAX_OUT=4. Single request: req 2 with x=144. Expect req_rdy=0100 in the same cycle and isqrt_x=144. Once isqrt returns, rsp_vld=0100 and rsp_y=12 one cycle after isqrt_y_vld.
- All four requesters held valid (x=1,4,9,16), isqrt latency 8. Expect grants in order 0,1,2,3; then count=4 and no further grant. Responses 1,2,3,4 route to 0001,0010,0100,1000 in order.
- Full plus simultaneous pop: count=4 with isqrt_y_vld=1 and req 1 valid. Expect no grant that cycle and a grant to req 1 the next cycle; count goes 4, 3, 4.
- Round-robin: rr_ptr=3 with req_vld=1001. Expect a grant to 3 first, then 0.
- Reset pulse (rst_n=0 for 2 cycles) with 3 operations outstanding. Expect rsp_vld=0, busy=0 and req_rdy=0 immediately. After release, a new request for x=0 from requester 1 returns rsp_y=0 on rsp_vld=0010.
- With ISQRT_ARBITER_ERR_EN: isqrt_y_vld=1 while idle sets err=1, which stays 1 until reset. Without the macro, the same stimulus produces no response and no err port exists.
